// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port scoreboarded register file.
package regfile_pkg;

   localparam int ADDR_WIDTH_DEF = 5;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int X0_IDX         = 0;

   typedef logic [ADDR_WIDTH_DEF-1:0] reg_idx_t;
   typedef logic [DATA_WIDTH_DEF-1:0] data_t;

endpackage

// File: rtl/regfile_wr_sel.sv
// Combinational priority selector: does any enabled write port target idx_i, and with what data.
// Highest-index matching port wins; index 0 never hits.
module regfile_wr_sel
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int NUM_WR     = 2
) (
   input  logic [ADDR_WIDTH-1:0]        idx_i,
   input  logic [NUM_WR-1:0]            we_i,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] rw_i,
   input  logic [NUM_WR*DATA_WIDTH-1:0] wdata_i,
   output logic                         hit_o,
   output logic [DATA_WIDTH-1:0]        data_o
);

   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      // Ascending scan so a later (higher-index) match overrides earlier ones.
      for (int k = 0; k < NUM_WR; k++) begin
         if (we_i[k] && (rw_i[k*ADDR_WIDTH +: ADDR_WIDTH] == idx_i) &&
             (idx_i != ADDR_WIDTH'(X0_IDX))) begin
            hit_o  = 1'b1;
            data_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with per-register busy scoreboard; reads are zero-latency, writes land on the edge.
// Same-cycle write forwarding to read ports is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int NUM_RD     = 4,
   parameter int NUM_WR     = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NUM_WR-1:0]            we_i,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] rw_i,
   input  logic [NUM_WR*DATA_WIDTH-1:0] wdata_i,
   input  logic                         alloc_i,
   input  logic [ADDR_WIDTH-1:0]        alloc_rd_i,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] ra_i,
   output logic [NUM_RD*DATA_WIDTH-1:0] rdata_o,
   output logic [NUM_RD-1:0]            rready_o,
   output logic [2**ADDR_WIDTH-1:0]     busy_o
);

   localparam int NREG = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [1:NREG-1];
   logic [DATA_WIDTH-1:0] regs_d [1:NREG-1];
   logic [NREG-1:1]       busy_q;
   logic [NREG-1:1]       busy_d;
   logic [NREG-1:1]       wr_hit;
   logic [DATA_WIDTH-1:0] wr_dat [1:NREG-1];
   logic [NUM_RD-1:0]     byp_hit;
   logic [DATA_WIDTH-1:0] byp_dat [NUM_RD];

   for (genvar i = 1; i < NREG; i++) begin : g_wsel
      regfile_wr_sel #(
         .ADDR_WIDTH (ADDR_WIDTH),
         .DATA_WIDTH (DATA_WIDTH),
         .NUM_WR     (NUM_WR)
      ) u_wr_sel (
         .idx_i   (ADDR_WIDTH'(i)),
         .we_i    (we_i),
         .rw_i    (rw_i),
         .wdata_i (wdata_i),
         .hit_o   (wr_hit[i]),
         .data_o  (wr_dat[i])
      );
   end

`ifdef REGFILE_MP_BYPASS_EN
   for (genvar p = 0; p < NUM_RD; p++) begin : g_byp
      regfile_wr_sel #(
         .ADDR_WIDTH (ADDR_WIDTH),
         .DATA_WIDTH (DATA_WIDTH),
         .NUM_WR     (NUM_WR)
      ) u_byp_sel (
         .idx_i   (ra_i[p*ADDR_WIDTH +: ADDR_WIDTH]),
         .we_i    (we_i),
         .rw_i    (rw_i),
         .wdata_i (wdata_i),
         .hit_o   (byp_hit[p]),
         .data_o  (byp_dat[p])
      );
   end
`else
   assign byp_hit = '0;
   for (genvar p = 0; p < NUM_RD; p++) begin : g_nobyp
      assign byp_dat[p] = '0;
   end
`endif

   // Alloc is applied after writes so a same-cycle alloc leaves the register pending.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int i = 1; i < NREG; i++) begin
         if (wr_hit[i]) begin
            regs_d[i] = wr_dat[i];
            busy_d[i] = 1'b0;
         end
      end
      if (alloc_i && (alloc_rd_i != ADDR_WIDTH'(X0_IDX))) begin
         busy_d[alloc_rd_i] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 1; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   always_comb begin
      logic [ADDR_WIDTH-1:0] ra;
      ra       = '0;
      rdata_o  = '0;
      rready_o = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         ra = ra_i[p*ADDR_WIDTH +: ADDR_WIDTH];
         if (byp_hit[p]) begin
            rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = byp_dat[p];
            rready_o[p]                         = 1'b1;
         end else if (ra == ADDR_WIDTH'(X0_IDX)) begin
            rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = '0;
            rready_o[p]                         = 1'b1;
         end else begin
            rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra];
            rready_o[p]                         = ~busy_q[ra];
         end
      end
   end

   assign busy_o = {busy_q, 1'b0};

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomized bench for regfile_mp_sb against an array-based model, plus directed literal checks.
module tb_regfile_mp_sb;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 4;
   localparam int NW = 2;
   localparam int NREG = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [NW-1:0]   we;
   logic [NW*AW-1:0] rw;
   logic [NW*DW-1:0] wdata;
   logic            alloc;
   logic [AW-1:0]   alloc_rd;
   logic [NR*AW-1:0] ra;
   logic [NR*DW-1:0] rdata;
   logic [NR-1:0]   rready;
   logic [NREG-1:0] busy;

   int n_cmp = 0;
   int n_bad = 0;

   regfile_mp_sb #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_RD     (NR),
      .NUM_WR     (NW)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .we_i       (we),
      .rw_i       (rw),
      .wdata_i    (wdata),
      .alloc_i    (alloc),
      .alloc_rd_i (alloc_rd),
      .ra_i       (ra),
      .rdata_o    (rdata),
      .rready_o   (rready),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   // Behavioural model: plain arrays of values and pending flags.
   logic [DW-1:0] mem [NREG];
   bit            mbusy [NREG];
   bit            mvalid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i]   = '0;
            mbusy[i] = 1'b0;
         end
         mvalid = 1'b1;
      end else begin
         for (int k = 0; k < NW; k++) begin
            if (we[k] && rw[k*AW +: AW] != 0) begin
               mem[rw[k*AW +: AW]]   = wdata[k*DW +: DW];
               mbusy[rw[k*AW +: AW]] = 1'b0;
            end
         end
         if (alloc && alloc_rd != 0) mbusy[alloc_rd] = 1'b1;
      end
   end

   task automatic model_read(input int p, output logic [DW-1:0] d, output logic r);
      int a;
      a = ra[p*AW +: AW];
      d = mem[a];
      r = !mbusy[a];
      if (a == 0) begin
         d = '0;
         r = 1'b1;
      end
`ifdef REGFILE_MP_BYPASS_EN
      for (int k = 0; k < NW; k++) begin
         if (a != 0 && we[k] && rw[k*AW +: AW] == a) begin
            d = wdata[k*DW +: DW];
            r = 1'b1;
         end
      end
`endif
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous comparison against the model on every cycle after the first reset edge.
   always @(negedge clk) begin
      if (mvalid) begin
         logic [DW-1:0]   ed;
         logic            er;
         logic [NREG-1:0] eb;
         for (int p = 0; p < NR; p++) begin
            model_read(p, ed, er);
            chk($sformatf("model_rdata%0d", p), 64'(rdata[p*DW +: DW]), 64'(ed));
            chk($sformatf("model_rready%0d", p), 64'(rready[p]), 64'(er));
         end
         for (int i = 0; i < NREG; i++) eb[i] = mbusy[i];
         eb[0] = 1'b0;
         chk("model_busy", 64'(busy), 64'(eb));
      end
   end

   task automatic idle();
      rst      = 1'b0;
      we       = '0;
      rw       = '0;
      wdata    = '0;
      alloc    = 1'b0;
      alloc_rd = '0;
      ra       = '0;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic set_wr(input int k, input int a, input logic [DW-1:0] d);
      we[k]          = 1'b1;
      rw[k*AW +: AW] = AW'(a);
      wdata[k*DW +: DW] = d;
   endtask

   task automatic set_ra(input int p, input int a);
      ra[p*AW +: AW] = AW'(a);
   endtask

   function automatic int rnd_addr();
      if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NREG-1));
      return int'($urandom_range(0, 7));
   endfunction

   initial begin
      logic [DW-1:0] same_cycle_exp;
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      next();

      // Reset state across a spread of addresses.
      set_ra(0, 0); set_ra(1, 1); set_ra(2, 31); set_ra(3, 17);
      @(negedge clk);
      chk("rst_rdata", 64'(rdata), 64'(0));
      chk("rst_rready", 64'(rready), 64'(4'hF));
      chk("rst_busy", 64'(busy), 64'(0));

      // Write then read-after-write.
      next();
      set_wr(0, 5, 32'hDEADBEEF);
      set_ra(0, 5);
`ifdef REGFILE_MP_BYPASS_EN
      same_cycle_exp = 32'hDEADBEEF;
`else
      same_cycle_exp = 32'h0;
`endif
      @(negedge clk);
      chk("raw_same_cycle", 64'(rdata[0 +: DW]), 64'(same_cycle_exp));
      next();
      set_ra(0, 5);
      @(negedge clk);
      chk("raw_next_data", 64'(rdata[0 +: DW]), 64'h0000_0000_DEAD_BEEF);
      chk("raw_next_rdy", 64'(rready[0]), 64'(1));

      // Alloc makes a register pending until its writeback.
      next();
      alloc = 1'b1; alloc_rd = 5'd7;
      next();
      set_ra(1, 7);
      @(negedge clk);
      chk("alloc_rdy", 64'(rready[1]), 64'(0));
      chk("alloc_busy", 64'(busy[7]), 64'(1));
      next();
      set_wr(1, 7, 32'h12);
      next();
      set_ra(1, 7);
      @(negedge clk);
      chk("wb_data", 64'(rdata[DW +: DW]), 64'h12);
      chk("wb_rdy", 64'(rready[1]), 64'(1));
      chk("wb_busy", 64'(busy[7]), 64'(0));

      // Write collision plus same-cycle alloc.
      next();
      set_wr(0, 9, 32'hAAAA);
      set_wr(1, 9, 32'h5555);
      alloc = 1'b1; alloc_rd = 5'd9;
      next();
      set_ra(2, 9);
      @(negedge clk);
      chk("coll_data", 64'(rdata[2*DW +: DW]), 64'h5555);
      chk("coll_busy", 64'(busy[9]), 64'(1));
      chk("coll_rdy", 64'(rready[2]), 64'(0));

      // x0 ignores writes and allocs.
      next();
      set_wr(0, 0, 32'hFFFF_FFFF);
      alloc = 1'b1; alloc_rd = 5'd0;
      set_ra(3, 0);
      @(negedge clk);
      chk("x0_same_data", 64'(rdata[3*DW +: DW]), 64'(0));
      next();
      set_ra(3, 0);
      @(negedge clk);
      chk("x0_data", 64'(rdata[3*DW +: DW]), 64'(0));
      chk("x0_rdy", 64'(rready[3]), 64'(1));
      chk("x0_busy", 64'(busy[0]), 64'(0));

      // Reset in the middle of activity wins over a same-cycle write.
      next();
      set_wr(0, 3, 32'h33);
      set_wr(1, 4, 32'h44);
      next();
      alloc = 1'b1; alloc_rd = 5'd3;
      next();
      set_ra(0, 3); set_ra(1, 4);
      @(negedge clk);
      chk("pre_rst_rdy3", 64'(rready[0]), 64'(0));
      chk("pre_rst_data4", 64'(rdata[DW +: DW]), 64'h44);
      next();
      rst = 1'b1;
      set_wr(0, 4, 32'h99);
      next();
      set_ra(0, 3); set_ra(1, 4);
      @(negedge clk);
      chk("mid_rst_data3", 64'(rdata[0 +: DW]), 64'(0));
      chk("mid_rst_data4", 64'(rdata[DW +: DW]), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));

      // Randomized traffic, concentrated on a few registers to provoke collisions.
      for (int c = 0; c < 3000; c++) begin
         next();
         rst = ($urandom_range(0, 99) == 0);
         for (int k = 0; k < NW; k++) begin
            if ($urandom_range(0, 1) == 1) set_wr(k, rnd_addr(), $urandom());
         end
         alloc    = ($urandom_range(0, 2) == 0);
         alloc_rd = AW'(rnd_addr());
         for (int p = 0; p < NR; p++) set_ra(p, rnd_addr());
      end
      next();
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
